// File: rtl/sdram_frame_bank_sched.sv
// ---------------------------------------------------------------------------
// sdram_frame_bank_sched
//
// Frame-level bank scheduler for the LCD resize path (SDRAM controller clock
// domain). Tracks the state of each SDRAM frame bank and decides which bank
// the write FIFO port fills and which bank the read FIFO port scans. The
// reader never touches a bank under write and always picks up the newest
// complete frame.
//
// Ports:
//   clk_ref           SDRAM controller clock
//   rst               asynchronous active-high reset
//   enable            scheduler enable; low frees every bank (synchronously)
//   wr_frame_start    pulse: writer begins a new frame
//   wr_frame_done     pulse: writer finished the frame's last burst
//   rd_frame_start    pulse: display begins a new frame scan
//   wr_bank/rd_bank   bank assigned to writer / reader
//   wr_base_addr      wr_bank << BANK_SHIFT
//   rd_base_addr      rd_bank << BANK_SHIFT
//   wr_busy           writer owns a WRITING bank
//   rd_valid          reader owns a READING bank with a complete frame
//   frame_drop_cnt    saturating count of discarded frames
//   frame_repeat_cnt  saturating count of repeated display frames
//
// NUM_BANKS is legal in 2..4 (bank index is 2 bits wide).
// ---------------------------------------------------------------------------
module sdram_frame_bank_sched #(
    parameter int NUM_BANKS  = 3,
    parameter int BANK_SHIFT = 20,
    parameter int ADDR_W     = 24,
    parameter int CNT_W      = 8
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic [ADDR_W-1:0] rd_base_addr,
    output logic              wr_busy,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  frame_drop_cnt,
    output logic [CNT_W-1:0]  frame_repeat_cnt
);

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_WRITING = 2'd1,
        B_READY   = 2'd2,
        B_READING = 2'd3
    } bank_st_t;

    typedef logic [NUM_BANKS-1:0] bmask_t;

    bank_st_t [NUM_BANKS-1:0] st_q;
    bank_st_t [NUM_BANKS-1:0] st_d;

    logic [1:0] wr_bank_d;
    logic [1:0] rd_bank_d;
    logic [1:0] drop_inc;
    logic [1:0] rep_inc;

    // Per-stage bank masks of the event chain.
    bmask_t wm_done, rm_done;
    bmask_t rm_rd, gm_rd;
    bmask_t wm_st, fm_st, claim;

    // One bit per bank that is currently in state 'code'.
    function automatic bmask_t match(input bank_st_t [NUM_BANKS-1:0] s,
                                     input bank_st_t code);
        bmask_t m;
        m = '0;
        for (int i = 0; i < NUM_BANKS; i++) m[i] = (s[i] == code);
        return m;
    endfunction

    // Isolate the lowest set bit.
    function automatic bmask_t lowest(input bmask_t v);
        return v & (~v + bmask_t'(1));
    endfunction

    function automatic logic [1:0] enc(input bmask_t m);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) if (m[i]) idx = 2'(i);
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] b);
        return {{(ADDR_W-2){1'b0}}, b} << BANK_SHIFT;
    endfunction

    // Same-cycle events are applied as one chain: done, then read start,
    // then write start. Each stage sees the result of the previous one, so
    // a frame finished this cycle can be displayed this cycle and its old
    // reading bank can be reclaimed by the writer in the same update.
    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        drop_inc  = '0;
        rep_inc   = '0;
        wm_done   = '0;
        rm_done   = '0;
        rm_rd     = '0;
        gm_rd     = '0;
        wm_st     = '0;
        fm_st     = '0;
        claim     = '0;

        if (!enable) begin
            for (int i = 0; i < NUM_BANKS; i++) st_d[i] = B_FREE;
        end else begin
            // Frame complete: publish it, discarding an older unread frame.
            wm_done = match(st_d, B_WRITING);
            rm_done = match(st_d, B_READY);
            if (wr_frame_done && (|wm_done)) begin
                if (|rm_done) drop_inc = drop_inc + 2'd1;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (rm_done[i]) st_d[i] = B_FREE;
                    if (wm_done[i]) st_d[i] = B_READY;
                end
            end

            // Display start: move to the newest frame, else repeat.
            rm_rd = match(st_d, B_READY);
            gm_rd = match(st_d, B_READING);
            if (rd_frame_start) begin
                if (|rm_rd) begin
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (gm_rd[i]) st_d[i] = B_FREE;
                        if (rm_rd[i]) st_d[i] = B_READING;
                    end
                    rd_bank_d = enc(rm_rd);
                end else if (|gm_rd) begin
                    rep_inc = 2'd1;
                end
            end

            // Writer start: abort an unfinished frame, then claim the lowest
            // FREE bank. With only two banks there may be none free; the
            // pending READY frame is then sacrificed. READING is never taken.
            if (wr_frame_start) begin
                wm_st = match(st_d, B_WRITING);
                if (|wm_st) begin
                    drop_inc = drop_inc + 2'd1;
                    for (int i = 0; i < NUM_BANKS; i++)
                        if (wm_st[i]) st_d[i] = B_FREE;
                end
                fm_st = lowest(match(st_d, B_FREE));
                if (|fm_st) begin
                    claim = fm_st;
                end else begin
                    claim    = match(st_d, B_READY);
                    drop_inc = drop_inc + 2'd1;
                end
                for (int i = 0; i < NUM_BANKS; i++)
                    if (claim[i]) st_d[i] = B_WRITING;
                wr_bank_d = enc(claim);
            end
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) st_q[i] <= B_FREE;
            wr_bank          <= '0;
            rd_bank          <= '0;
            wr_base_addr     <= '0;
            rd_base_addr     <= '0;
            wr_busy          <= 1'b0;
            rd_valid         <= 1'b0;
            frame_drop_cnt   <= '0;
            frame_repeat_cnt <= '0;
        end else begin
            st_q             <= st_d;
            wr_bank          <= wr_bank_d;
            rd_bank          <= rd_bank_d;
            wr_base_addr     <= base_of(wr_bank_d);
            rd_base_addr     <= base_of(rd_bank_d);
            wr_busy          <= |match(st_d, B_WRITING);
            rd_valid         <= |match(st_d, B_READING);
            frame_drop_cnt   <= sat_add(frame_drop_cnt, drop_inc);
            frame_repeat_cnt <= sat_add(frame_repeat_cnt, rep_inc);
        end
    end

endmodule

// File: tb/tb_sdram_frame_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_sdram_frame_bank_sched
//
// Self-checking bench. dut_a runs with three banks, dut_b with two; both
// share clock, reset and enable. Each scenario task pushes the expected
// output snapshot into a scoreboard queue as it drives a pulse, then pops
// and compares it once the registered outputs have settled.
// ---------------------------------------------------------------------------
module tb_sdram_frame_bank_sched;

    localparam int AW = 24;
    localparam int CW = 8;
    localparam int BS = 20;

    logic clk_ref = 1'b0;
    logic rst     = 1'b1;
    logic enable  = 1'b1;
    logic d1 = 1'b0, r1 = 1'b0, s1 = 1'b0;
    logic d2 = 1'b0, r2 = 1'b0, s2 = 1'b0;

    logic [1:0]    wb1, rb1, wb2, rb2;
    logic [AW-1:0] wa1, ra1, wa2, ra2;
    logic          busy1, valid1, busy2, valid2;
    logic [CW-1:0] drop1, rep1, drop2, rep2;

    always #5 clk_ref = ~clk_ref;

    sdram_frame_bank_sched #(.NUM_BANKS(3), .BANK_SHIFT(BS), .ADDR_W(AW), .CNT_W(CW)) dut_a (
        .clk_ref(clk_ref), .rst(rst), .enable(enable),
        .wr_frame_start(s1), .wr_frame_done(d1), .rd_frame_start(r1),
        .wr_bank(wb1), .rd_bank(rb1), .wr_base_addr(wa1), .rd_base_addr(ra1),
        .wr_busy(busy1), .rd_valid(valid1),
        .frame_drop_cnt(drop1), .frame_repeat_cnt(rep1)
    );

    sdram_frame_bank_sched #(.NUM_BANKS(2), .BANK_SHIFT(BS), .ADDR_W(AW), .CNT_W(CW)) dut_b (
        .clk_ref(clk_ref), .rst(rst), .enable(enable),
        .wr_frame_start(s2), .wr_frame_done(d2), .rd_frame_start(r2),
        .wr_bank(wb2), .rd_bank(rb2), .wr_base_addr(wa2), .rd_base_addr(ra2),
        .wr_busy(busy2), .rd_valid(valid2),
        .frame_drop_cnt(drop2), .frame_repeat_cnt(rep2)
    );

    typedef struct packed {
        logic [1:0]    wb;
        logic [1:0]    rb;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic          busy;
        logic          valid;
        logic [CW-1:0] drop;
        logic [CW-1:0] rep;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic snap_t mk(int wb, int rb, bit busy, bit valid, int drop, int rep);
        snap_t e;
        e.wb    = 2'(wb);
        e.rb    = 2'(rb);
        e.wa    = AW'(wb) << BS;
        e.ra    = AW'(rb) << BS;
        e.busy  = busy;
        e.valid = valid;
        e.drop  = CW'(drop);
        e.rep   = CW'(rep);
        return e;
    endfunction

    function automatic snap_t snap_a();
        return {wb1, rb1, wa1, ra1, busy1, valid1, drop1, rep1};
    endfunction

    function automatic snap_t snap_b();
        return {wb2, rb2, wa2, ra2, busy2, valid2, drop2, rep2};
    endfunction

    // One-cycle pulse on dut_a; returns on the negedge after the capturing edge.
    task automatic pulse_a(input bit d, input bit r, input bit s);
        @(negedge clk_ref);
        d1 = d; r1 = r; s1 = s;
        @(negedge clk_ref);
        d1 = 1'b0; r1 = 1'b0; s1 = 1'b0;
    endtask

    task automatic pulse_b(input bit d, input bit r, input bit s);
        @(negedge clk_ref);
        d2 = d; r2 = r; s2 = s;
        @(negedge clk_ref);
        d2 = 1'b0; r2 = 1'b0; s2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_ref);
        rst = 1'b1;
        @(negedge clk_ref);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        snap_t got, e;
        rst = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk_ref);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_a got %h want %h", got, e); end
        got = snap_b(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_b got %h want %h", got, e); end
        rst = 1'b0;
        // done with nothing writing, then read start with nothing ready: no change
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        pulse_a(1, 0, 0);
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL idle_done got %h want %h", got, e); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        pulse_a(0, 1, 0);
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL idle_read got %h want %h", got, e); end
    endtask

    task automatic test_first_frame();
        bit [2:0] stim [3];   // {done, rd_start, wr_start}
        snap_t    e    [3];
        snap_t    got, ex;
        stim = '{3'b001, 3'b100, 3'b010};
        e[0] = mk(0, 0, 1, 0, 0, 0);
        e[1] = mk(0, 0, 0, 0, 0, 0);
        e[2] = mk(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(e[k]);
            pulse_a(stim[k][2], stim[k][1], stim[k][0]);
            got = snap_a(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL first_frame[%0d] got %h want %h", k, got, ex); end
        end
    endtask

    // Writer outpaces reader: third finished frame discards the unread one.
    task automatic test_steady_flow();
        bit [2:0] stim [5];
        snap_t    e    [5];
        snap_t    got, ex;
        stim = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001};
        e[0] = mk(1, 0, 1, 1, 0, 0);
        e[1] = mk(1, 0, 0, 1, 0, 0);
        e[2] = mk(2, 0, 1, 1, 0, 0);
        e[3] = mk(2, 0, 0, 1, 1, 0);
        e[4] = mk(1, 0, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(e[k]);
            pulse_a(stim[k][2], stim[k][1], stim[k][0]);
            got = snap_a(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL steady_flow[%0d] got %h want %h", k, got, ex); end
        end
    endtask

    // Reader outpaces writer: repeats the displayed frame.
    task automatic test_reader_faster();
        bit [2:0] stim [6];
        snap_t    e    [6];
        snap_t    got, ex;
        do_reset();
        stim = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b010};
        e[0] = mk(0, 0, 1, 0, 0, 0);
        e[1] = mk(0, 0, 0, 0, 0, 0);
        e[2] = mk(0, 0, 0, 1, 0, 0);
        e[3] = mk(1, 0, 1, 1, 0, 0);
        e[4] = mk(1, 0, 1, 1, 0, 1);
        e[5] = mk(1, 0, 1, 1, 0, 2);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(e[k]);
            pulse_a(stim[k][2], stim[k][1], stim[k][0]);
            got = snap_a(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL reader_faster[%0d] got %h want %h", k, got, ex); end
        end
    endtask

    // Bank 1 WRITING, bank 0 READING; all three pulses together.
    task automatic test_same_cycle();
        snap_t got, e;
        exp_q.push_back(mk(0, 1, 1, 1, 0, 2));
        pulse_a(1, 1, 1);
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL same_cycle got %h want %h", got, e); end
    endtask

    // One cycle of enable low with pulses that must be ignored.
    task automatic test_enable();
        bit [2:0] stim [4];
        snap_t    e    [4];
        snap_t    got, ex;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 2));
        @(negedge clk_ref);
        enable = 1'b0; r1 = 1'b1; s1 = 1'b1; d1 = 1'b1;
        @(negedge clk_ref);
        enable = 1'b1; r1 = 1'b0; s1 = 1'b0; d1 = 1'b0;
        got = snap_a(); ex = exp_q.pop_front(); checks++;
        if (got !== ex) begin errors++; $display("FAIL enable_low got %h want %h", got, ex); end
        stim = '{3'b001, 3'b010, 3'b100, 3'b010};
        e[0] = mk(0, 1, 1, 0, 0, 2);
        e[1] = mk(0, 1, 1, 0, 0, 2);
        e[2] = mk(0, 1, 0, 0, 0, 2);
        e[3] = mk(0, 0, 0, 1, 0, 2);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(e[k]);
            pulse_a(stim[k][2], stim[k][1], stim[k][0]);
            got = snap_a(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL after_enable[%0d] got %h want %h", k, got, ex); end
        end
    endtask

    // Two banks: no FREE bank forces reuse of the READY one; then an abort.
    task automatic test_two_banks();
        bit [2:0] stim [8];
        snap_t    e    [8];
        snap_t    got, ex;
        stim = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001, 3'b001, 3'b010};
        e[0] = mk(0, 0, 1, 0, 0, 0);
        e[1] = mk(0, 0, 0, 0, 0, 0);
        e[2] = mk(0, 0, 0, 1, 0, 0);
        e[3] = mk(1, 0, 1, 1, 0, 0);
        e[4] = mk(1, 0, 0, 1, 0, 0);
        e[5] = mk(1, 0, 1, 1, 1, 0);
        e[6] = mk(1, 0, 1, 1, 2, 0);
        e[7] = mk(1, 0, 1, 1, 2, 1);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(e[k]);
            pulse_b(stim[k][2], stim[k][1], stim[k][0]);
            got = snap_b(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL two_banks[%0d] got %h want %h", k, got, ex); end
        end
    endtask

    // Repeated aborts drive the drop counter into saturation.
    task automatic test_saturation();
        snap_t got, e;
        do_reset();
        pulse_a(0, 0, 1);
        for (int i = 1; i <= 300; i++) begin
            pulse_a(0, 0, 1);
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                exp_q.push_back(mk(0, 0, 1, 0, (i > 255) ? 255 : i, 0));
                got = snap_a(); e = exp_q.pop_front(); checks++;
                if (got !== e) begin errors++; $display("FAIL saturate[%0d] got %h want %h", i, got, e); end
            end
        end
    endtask

    // Reset mid-frame clears outputs without waiting for a clock edge.
    task automatic test_async_reset();
        snap_t got, e;
        @(negedge clk_ref);
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL async_reset got %h want %h", got, e); end
        @(negedge clk_ref);
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
        pulse_a(0, 0, 1);
        got = snap_a(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset_start got %h want %h", got, e); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_steady_flow();
        test_reader_faster();
        test_same_cycle();
        test_enable();
        test_two_banks();
        test_saturation();
        test_async_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
